shift194_ctrl: RTL and testbench
================================

Name: shift194_ctrl

Overview:
- Upstream sequencer for the team's 4-bit universal shift register (S_74HC194 model). It drives that block's S, DS and D inputs.
- Accepts one 4-bit word per valid/ready handshake. It parallel-loads the word into the shifter, then issues N_SHIFT shift commands in the requested direction.
- Samples the shifter's serial-out end from Q each shift cycle, producing a serial bit stream with a valid strobe.
- Together the two blocks form a parallel-to-serial transmitter.

Parameters:
- N_SHIFT, 4, number of shift cycles per word (1..15).
- CW, 4, width of internal shift counter; must satisfy 2**CW > N_SHIFT.

Ports:
- CP  input  1  clock, rising edge.
- CR  input  1  reset, synchronous, active-high.
- in_valid  input  1  word available.
- in_ready  output  1  controller can accept a word.
- in_data  input  4  word to load.
- in_dir  input  1  0 = shift right (toward Q[3]), 1 = shift left (toward Q[0]).
- in_fill  input  1  bit shifted in via DS during the shift phase.
- S  output  2  shifter mode: 00 hold, 01 right, 10 left, 11 parallel load.
- DS  output  1  serial data into shifter.
- D  output  4  parallel data into shifter.
- Q  input  4  shifter outputs, fed back.
- ser_out  output  1  serial bit taken from shifter.
- ser_valid  output  1  ser_out valid this cycle.
- done  output  1  one-cycle pulse, word fully shifted.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Clocking and reset:
  - Single clock CP.
  - CR is synchronous, active-high.
  - All outputs are registered except in_ready and busy, which decode state.
- Reset values: state = IDLE, S = 00, DS = 0, D = 0000, ser_out = 0, ser_valid = 0, done = 0, counter = 0, in_ready = 1, busy = 0.
- Shifter convention, stated for bench and implementer:
  - S = 01: Q[0] <= DS, Q[i] <= Q[i-1]; serial end is Q[3].
  - S = 10: Q[3] <= DS, Q[i] <= Q[i+1]; serial end is Q[0].
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - in_ready = 1 and S = 00.
  - On an edge with in_valid = 1:
    - Latch in_data into D and in_dir/in_fill into internal registers.
    - Set S = 11 and DS = in_fill.
    - Go to LOAD.
- LOAD (one cycle):
  - The shifter loads D at the closing edge.
  - At that edge, S becomes 01 (dir = 0) or 10 (dir = 1), counter is cleared, and state goes to SHIFT.
- SHIFT (exactly N_SHIFT cycles):
  - At each edge:
    - ser_out <= Q[3] (dir = 0) or Q[0] (dir = 1), i.e. the bit about to leave the shifter.
    - ser_valid <= 1.
    - Counter increments.
  - On the edge where counter == N_SHIFT-1:
    - S <= 00.
    - done <= 1.
    - State goes to DONE.
- DONE (one cycle):
  - ser_valid and done are high for this cycle only.
  - Then go to IDLE.
  - A new word can be accepted on the edge that leaves IDLE, not in DONE.
- Timing:
  - Latency from the accept edge to the first ser_valid is 3 cycles.
  - Throughput is one word per N_SHIFT + 3 cycles.
- Bit order:
  - dir = 0 emits in_data[3], [2], [1], [0] (MSB first).
  - dir = 1 emits [0], [1], [2], [3] (LSB first).
  - With N_SHIFT = 4, the final Q is {4{fill}}.
- N_SHIFT > 4: bits 5 and later are fill bits.
- ser_valid outside SHIFT-generated cycles: 0. ser_out holds its last value.
- in_valid while busy: ignored. in_ready = 0; the upstream must hold the data.
- CR asserted mid-operation:
  - Next edge forces the reset values, including S = 00 so the shifter holds.
  - No done pulse is issued and the partial word is discarded.
- in_data/in_dir/in_fill changing after accept: no effect on the current word.

Decomposition:
- Package shift194_pkg holds:
  - the state encoding (IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3);
  - the S mode constants S_HOLD = 2'b00, S_RIGHT = 2'b01, S_LEFT = 2'b10, S_LOAD = 2'b11;
  - the direction constants DIR_R = 0, DIR_L = 1.
- One sub-module, shift_cnt: a 74HC161-style synchronous up-counter with clear, enable and terminal-count flag (tc when count == N_SHIFT-1). It is instantiated for the shift count.

Test Plan:
- Bench connects the controller to S_74HC194 with CR_n = ~CR at 100 MHz.
- Reset: CR = 1 for 3 cycles → S = 00, in_ready = 1, busy = 0, ser_valid = 0, done = 0.
- Right shift: in_data = 1101, dir = 0, fill = 0 →
  - S sequence 11, 01×4, 00;
  - ser_out stream 1, 1, 0, 1;
  - done pulses once;
  - final Q = 0000.
- Left shift: in_data = 1101, dir = 1, fill = 1 →
  - ser_out stream 1, 0, 1, 1;
  - final Q = 1111;
  - first ser_valid 3 cycles after the accept edge.
- Back-to-back: in_valid held high with 1010 then 0101 (dir = 0) →
  - the second word is accepted on the first IDLE edge after DONE;
  - stream 1, 0, 1, 0, 0, 1, 0, 1;
  - in_ready = 0 throughout each word.
- Reset mid-shift: assert CR after the 2nd shift bit →
  - next edge gives S = 00, ser_valid = 0, no done pulse, state IDLE;
  - a following word shifts correctly.
- N_SHIFT = 6, in_data = 1000, dir = 0, fill = 1 → stream 1, 0, 0, 0, 1, 1; done after 6 bits.

Source files
------------

// File: rtl/shift194_ctrl_pkg.sv
// Shared types and constants for the 74HC194 sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, shifter S-mode codes, direction codes and
// small decode helpers used by the controller.
package shift194_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Shifter S[1:0] mode codes.
  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  // Shift direction codes.
  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  // Shift mode that moves data toward the serial end for a direction.
  function automatic logic [1:0] shift_mode(input logic dir);
    return (dir == DIR_L) ? S_LEFT : S_RIGHT;
  endfunction

  // Index into Q of the bit about to leave the shifter: Q[3] when shifting
  // right, Q[0] when shifting left.
  function automatic logic [1:0] serial_end(input logic dir);
    return (dir == DIR_L) ? 2'd0 : 2'd3;
  endfunction

endpackage

// File: rtl/shift194_ctrl_if.sv
// Word-input handshake between an upstream source and the 194 sequencer.
// Latency: n/a (wires only).
// Backpressure: source holds in_data/in_dir/in_fill while in_valid && !in_ready.
// Signals: in_valid/in_ready handshake, in_data word, in_dir shift direction,
// in_fill serial fill bit. master = upstream source, slave = controller.
interface shift194_ctrl_if;

  logic                              in_valid;
  logic                              in_ready;
  logic [shift194_pkg::DATA_W-1:0]   in_data;
  logic                              in_dir;
  logic                              in_fill;

  modport master (
    output in_valid, in_data, in_dir, in_fill,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_dir, in_fill,
    output in_ready
  );

endinterface

// File: rtl/shift194_ctrl_shift_cnt.sv
// 74HC161-style synchronous up-counter with clear, enable and terminal count.
// Latency: count updates on the edge after clr/en; tc is combinational on count.
// Backpressure: none; en simply holds the count when low.
// Ports: clk, rst (sync, active-high), clr (sync clear, wins over en), en,
// tc (high while count == N_SHIFT-1).
module shift_cnt #(
  parameter int N_SHIFT = 4,
  parameter int CW      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(N_SHIFT - 1));

endmodule

// File: rtl/shift194_ctrl.sv
// Sequencer driving a 74HC194 shifter as a parallel-to-serial transmitter.
// Latency: first ser_valid in the 3rd cycle after the accept edge; one word per N_SHIFT+3 cycles.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored and the source must hold.
// Ports: CP clock, CR sync active-high reset, up word handshake (slave),
// S/DS/D drive the shifter, Q shifter feedback, ser_out/ser_valid serial
// stream, done one-cycle end-of-word pulse, busy = not IDLE.
module shift194_ctrl
  import shift194_pkg::*;
#(
  parameter int N_SHIFT = 4,
  parameter int CW      = 4
) (
  input  logic                  CP,
  input  logic                  CR,
  shift194_ctrl_if.slave        up,
  output logic [1:0]            S,
  output logic                  DS,
  output logic [DATA_W-1:0]     D,
  input  logic [DATA_W-1:0]     Q,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  done,
  output logic                  busy
);

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [1:0]          s_d;
  logic                ds_d;
  logic [DATA_W-1:0]   d_d;
  logic                ser_out_d;
  logic                ser_valid_d;
  logic                done_d;
  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_tc;

  shift_cnt #(
    .N_SHIFT (N_SHIFT),
    .CW      (CW)
  ) u_shift_cnt (
    .clk (CP),
    .rst (CR),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  assign up.in_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    s_d         = S;
    ds_d        = DS;
    d_d         = D;
    ser_out_d   = ser_out;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        s_d = S_HOLD;
        if (up.in_valid) begin
          // The word and its options are captured here so later changes on
          // the input bus cannot disturb the word in flight. DS carries the
          // fill bit for the whole shift phase.
          d_d     = up.in_data;
          dir_d   = up.in_dir;
          ds_d    = up.in_fill;
          s_d     = S_LOAD;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Shifter takes D on this edge; shifting starts next cycle.
        s_d     = shift_mode(dir_q);
        cnt_clr = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Q still holds the pre-shift value at this edge, so the serial end
        // is the bit the shifter is about to drop.
        ser_out_d   = Q[serial_end(dir_q)];
        ser_valid_d = 1'b1;
        cnt_en      = 1'b1;
        if (cnt_tc) begin
          s_d     = S_HOLD;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      state_q   <= IDLE;
      dir_q     <= DIR_R;
      S         <= S_HOLD;
      DS        <= 1'b0;
      D         <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      S         <= s_d;
      DS        <= ds_d;
      D         <= d_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_shift194_ctrl.sv
// Bench for shift194_ctrl paired with a behavioural 74HC194 shifter.
// Latency: n/a.
// Backpressure: n/a.
// Two controller instances: N_SHIFT=4 (main) and N_SHIFT=6 (fill-bit case).
module tb_shift194_ctrl;
  import shift194_pkg::*;

  logic CP = 1'b0;
  logic CR = 1'b1;
  logic cr_n;
  always #5 CP = ~CP;
  assign cr_n = ~CR;

  shift194_ctrl_if if4 ();
  shift194_ctrl_if if6 ();

  logic [1:0] s4, s6;
  logic       ds4, ds6;
  logic [3:0] d4, d6, q4, q6;
  logic       so4, sv4, dn4, bz4;
  logic       so6, sv6, dn6, bz6;

  shift194_ctrl #(.N_SHIFT(4), .CW(4)) u_dut4 (
    .CP(CP), .CR(CR), .up(if4), .S(s4), .DS(ds4), .D(d4), .Q(q4),
    .ser_out(so4), .ser_valid(sv4), .done(dn4), .busy(bz4)
  );

  shift194_ctrl #(.N_SHIFT(6), .CW(4)) u_dut6 (
    .CP(CP), .CR(CR), .up(if6), .S(s6), .DS(ds6), .D(d6), .Q(q6),
    .ser_out(so6), .ser_valid(sv6), .done(dn6), .busy(bz6)
  );

  // Behavioural 74HC194: right moves toward Q[3], left toward Q[0].
  always @(posedge CP) begin
    if (!cr_n) q4 <= 4'b0000;
    else case (s4)
      S_RIGHT: q4 <= {q4[2:0], ds4};
      S_LEFT:  q4 <= {ds4, q4[3:1]};
      S_LOAD:  q4 <= d4;
      default: q4 <= q4;
    endcase
  end

  always @(posedge CP) begin
    if (!cr_n) q6 <= 4'b0000;
    else case (s6)
      S_RIGHT: q6 <= {q6[2:0], ds6};
      S_LEFT:  q6 <= {ds6, q6[3:1]};
      S_LOAD:  q6 <= d6;
      default: q6 <= q6;
    endcase
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel6, input logic v, input logic [3:0] d,
                       input logic dir, input logic fill);
    if (sel6) begin
      if6.in_valid = v; if6.in_data = d; if6.in_dir = dir; if6.in_fill = fill;
    end else begin
      if4.in_valid = v; if4.in_data = d; if4.in_dir = dir; if4.in_fill = fill;
    end
  endtask

  // Offers word da (called at a negedge with the DUT idle), then watches
  // ncyc cycles. Cycle c is sampled at the negedge after the (c-1)th edge
  // following the accept edge, so c=1 is the LOAD cycle. After the accept
  // edge the bus switches to db; valid stays up only when hold is set.
  task automatic run_word(input bit sel6, input logic [3:0] da, input logic dir_a,
                          input logic fill_a, input logic [3:0] db, input bit hold,
                          input int ncyc,
                          output logic [15:0] bits, output int nbits, output int ndone,
                          output int first_v, output int done_c,
                          output logic [15:0] s_seq, output int nready);
    logic v, o, dn, rdy;
    logic [1:0] s;
    bits = '0; nbits = 0; ndone = 0; first_v = 0; done_c = 0; s_seq = '0; nready = 0;
    drive(sel6, 1'b1, da, dir_a, fill_a);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge CP);
      if (c == 1) drive(sel6, hold, db, dir_a, fill_a);
      v   = sel6 ? sv6 : sv4;
      o   = sel6 ? so6 : so4;
      dn  = sel6 ? dn6 : dn4;
      rdy = sel6 ? if6.in_ready : if4.in_ready;
      s   = sel6 ? s6 : s4;
      if (v) begin
        bits = {bits[14:0], o};
        nbits++;
        if (first_v == 0) first_v = c;
      end
      if (dn) begin
        ndone++;
        done_c = c;
      end
      if (c <= 8) s_seq = {s_seq[13:0], s};
      if (rdy) nready++;
    end
    drive(sel6, 1'b0, db, dir_a, fill_a);
  endtask

  logic [15:0] bits, s_seq;
  int nbits, ndone, first_v, done_c, nready;
  int pre_bits, post_done;

  initial begin
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

    // Reset held for three edges.
    CR = 1'b1;
    repeat (3) @(posedge CP);
    @(negedge CP);
    check("rst_S",        32'(s4), 32'(2'b00));
    check("rst_in_ready", 32'(if4.in_ready), 32'd1);
    check("rst_busy",     32'(bz4), 32'd0);
    check("rst_ser_valid",32'(sv4), 32'd0);
    check("rst_done",     32'(dn4), 32'd0);
    check("rst_D_DS",     32'({d4, ds4}), 32'd0);
    check("rst_in_ready6",32'(if6.in_ready), 32'd1);
    CR = 1'b0;
    @(negedge CP);

    // Right shift, MSB first, fill 0.
    run_word(1'b0, 4'b1101, DIR_R, 1'b0, 4'b0010, 1'b0, 8,
             bits, nbits, ndone, first_v, done_c, s_seq, nready);
    check("right_S_seq",  32'(s_seq), 32'(16'b11_01_01_01_01_00_00_00));
    check("right_bits",   32'(bits[3:0]), 32'(4'b1101));
    check("right_nbits",  32'(nbits), 32'd4);
    check("right_ndone",  32'(ndone), 32'd1);
    check("right_done_c", 32'(done_c), 32'd6);
    check("right_Q",      32'(q4), 32'(4'b0000));

    // Left shift, LSB first, fill 1.
    run_word(1'b0, 4'b1101, DIR_L, 1'b1, 4'b0000, 1'b0, 8,
             bits, nbits, ndone, first_v, done_c, s_seq, nready);
    check("left_bits",    32'(bits[3:0]), 32'(4'b1011));
    check("left_Q",       32'(q4), 32'(4'b1111));
    check("left_latency", 32'(first_v), 32'd3);
    check("left_ndone",   32'(ndone), 32'd1);

    // Back-to-back with in_valid held: second word taken on the IDLE edge
    // after DONE (cycle 7 is IDLE, second DONE lands on cycle 13, cycle 14
    // is IDLE again and valid is dropped before its edge).
    run_word(1'b0, 4'b1010, DIR_R, 1'b0, 4'b0101, 1'b1, 14,
             bits, nbits, ndone, first_v, done_c, s_seq, nready);
    check("b2b_bits",     32'(bits[7:0]), 32'(8'b1010_0101));
    check("b2b_nbits",    32'(nbits), 32'd8);
    check("b2b_ndone",    32'(ndone), 32'd2);
    check("b2b_done_c",   32'(done_c), 32'd13);
    check("b2b_nready",   32'(nready), 32'd2);
    @(negedge CP);

    // Reset after the second serial bit.
    pre_bits = 0;
    drive(1'b0, 1'b1, 4'b1101, DIR_R, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CP);
      if (c == 1) drive(1'b0, 1'b0, 4'b0000, DIR_R, 1'b0);
      if (sv4) pre_bits++;
    end
    check("mid_pre_bits", 32'(pre_bits), 32'd2);
    CR = 1'b1;
    @(negedge CP);
    check("mid_S",        32'(s4), 32'(2'b00));
    check("mid_ser_valid",32'(sv4), 32'd0);
    check("mid_done",     32'(dn4), 32'd0);
    check("mid_idle",     32'({bz4, if4.in_ready}), 32'(2'b01));
    CR = 1'b0;
    post_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CP);
      if (dn4 || sv4) post_done++;
    end
    check("mid_no_done",  32'(post_done), 32'd0);
    run_word(1'b0, 4'b0011, DIR_L, 1'b0, 4'b1111, 1'b0, 8,
             bits, nbits, ndone, first_v, done_c, s_seq, nready);
    check("mid_next_bits",32'(bits[3:0]), 32'(4'b1100));
    check("mid_next_done",32'(ndone), 32'd1);

    // N_SHIFT = 6: two fill bits follow the word.
    run_word(1'b1, 4'b1000, DIR_R, 1'b1, 4'b0111, 1'b0, 10,
             bits, nbits, ndone, first_v, done_c, s_seq, nready);
    check("n6_bits",      32'(bits[5:0]), 32'(6'b100011));
    check("n6_nbits",     32'(nbits), 32'd6);
    check("n6_ndone",     32'(ndone), 32'd1);
    check("n6_done_c",    32'(done_c), 32'd8);
    check("n6_Q",         32'(q6), 32'(4'b1111));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
